ysyx_24100006_wbu: RTL and testbench
====================================

// Module: ysyx_24100006_wbu
// PURPOSE
//  Write-back unit: the producer side of the general-purpose register file write port.
//  Accepts one retiring instruction from EXU via valid/ready and waits for load data when needed.
//  Extracts and sign/zero-extends load data, then drives a single-cycle GPR write.
//  Emits a retire pulse and exposes the pending destination register for hazard checks.
// PARAMETERS
//  ADDR_WIDTH  4   GPR index width; must match the register file.
//  DATA_WIDTH  32  Datapath width; fixed at 32 because load extraction is RV32-only.
// PORTS
//  clk          in   1           clock; all state changes on posedge.
//  reset        in   1           synchronous, active-high reset.
//  in_valid     in   1           EXU offers an instruction.
//  in_ready     out  1           WBU can accept; high only in IDLE and not in reset.
//  in_rd        in   ADDR_WIDTH  destination register index.
//  in_reg_wen   in   1           instruction writes rd.
//  in_is_load   in   1           result comes from memory, not in_result.
//  in_funct3    in   3           load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
//  in_addr_lo   in   2           low 2 bits of the load byte address.
//  in_result    in   DATA_WIDTH  ALU/CSR/link result for non-loads.
//  mem_rvalid   in   1           load data is valid.
//  mem_rready   out  1           WBU accepts load data; high only in WAIT_MEM.
//  mem_rdata    in   DATA_WIDTH  aligned 32-bit word containing the load data.
//  gpr_wen      out  1           GPR write enable; registered, one cycle wide.
//  gpr_waddr    out  ADDR_WIDTH  GPR write index.
//  gpr_wdata    out  DATA_WIDTH  GPR write data.
//  wb_done      out  1           retire pulse; asserted in the same cycle as the write slot.
//  busy_valid   out  1           an accepted instruction has not yet retired.
//  busy_rd      out  ADDR_WIDTH  rd of that instruction; 0 when rd is not written.
// BEHAVIOUR
//  Reset (synchronous): state=IDLE, every output and internal latch = 0, in_ready=0, mem_rready=0.
//  FSM states:
//   IDLE:
//    - in_ready=1.
//    - Handshake when in_valid&in_ready: latch rd, reg_wen, funct3, addr_lo and result.
//    - Next state is WAIT_MEM if in_is_load, otherwise WRITE.
//   WAIT_MEM:
//    - mem_rready=1.
//    - On mem_rvalid: latch ext(mem_rdata), then go to WRITE.
//    - Stays in WAIT_MEM indefinitely without timeout.
//   WRITE:
//    - gpr_wen = latched reg_wen & (rd!=0).
//    - gpr_waddr = rd, gpr_wdata = latched data, wb_done=1.
//    - Next state is IDLE; in_ready is low in this cycle, so no bypass.
//  Latency:
//   - Non-load accepted at cycle T is written in cycle T+1; next accept possible at T+2.
//   - Load with mem_rvalid at cycle M is written in cycle M+1.
//  Load extraction:
//   - byte = rdata[8*addr_lo +: 8]; half = rdata[16*addr_lo[1] +: 16].
//   - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
//   - addr_lo[0] is ignored for halfwords (no misalignment trap here).
//   - Undefined funct3 (3, 6, 7) is treated as LW.
//  Outside the write slot: gpr_wen=0 and wb_done=0; gpr_waddr/gpr_wdata hold their last value.
//  rd==0 or reg_wen=0: retire still happens (wb_done=1) but gpr_wen=0.
//  busy_valid=1 in WAIT_MEM and WRITE; busy_rd = rd if reg_wen, else 0.
//  mem_rvalid while not in WAIT_MEM is ignored (mem_rready=0), with no state change.
//  in_valid while not in IDLE is not accepted; the EXU must hold its inputs stable until accepted.
//  Reset mid-operation (WAIT_MEM or WRITE):
//   - Return to IDLE; the pending write is dropped and gpr_wen=0 in the next cycle.
//   - A mem_rvalid arriving in the same cycle as reset is discarded.
// TESTING
//  1. ALU op: rd=5, reg_wen=1, result=0x1234_5678 accepted at T -> T+1: gpr_wen=1, waddr=5,
//     wdata=0x12345678, wb_done=1; at T+2 in_ready=1.
//  2. rd=0, reg_wen=1, result=0xFFFF_FFFF -> wb_done=1, gpr_wen=0.
//     A second op with reg_wen=0 gives the same response.
//  3. Load extraction, mem_rdata=0x8070_F0A5:
//     - LB,  addr_lo=0 -> 0xFFFF_FFA5; LBU, addr_lo=1 -> 0x0000_00F0;
//     - LH,  addr_lo=2 -> 0xFFFF_8070; LHU, addr_lo=2 -> 0x0000_8070;
//     - LW -> 0x8070_F0A5.
//  4. Load to rd=7 with mem_rvalid delayed by 5 cycles:
//     - mem_rready=1 throughout the wait; busy_valid=1, busy_rd=7; in_ready=0.
//     - Write occurs exactly 1 cycle after mem_rvalid.
//  5. Spurious mem_rvalid=1 while IDLE, and in_valid held high during WRITE ->
//     no write, no extra accept, state unchanged.
//  6. reset=1 during WAIT_MEM coincident with mem_rvalid -> next cycle IDLE; gpr_wen, wb_done,
//     busy_valid=0; the following ALU op writes normally.

Source files
------------

// File: rtl/ysyx_24100006_wbu.sv
// ysyx_24100006_wbu -- write-back unit, producer side of the GPR write port.
//
// Accepts one retiring instruction from the EXU through a valid/ready handshake.
// For a load it waits for the memory response, then extracts and extends the
// addressed byte, halfword or word. Either way it issues one registered GPR
// write slot, which also carries the retire pulse.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   in_valid/in_ready   EXU handshake; in_ready is high only in IDLE, outside reset
//   in_rd, in_reg_wen   destination register and its write enable
//   in_is_load          the result comes from memory instead of in_result
//   in_funct3           load type (LB/LH/LW/LBU/LHU; other codes behave as LW)
//   in_addr_lo          low two bits of the load byte address
//   in_result           ALU/CSR/link result for non-loads
//   mem_rvalid/rready   load-data handshake; mem_rready is high only in WAIT_MEM
//   mem_rdata           aligned 32-bit word that holds the load data
//   gpr_wen/waddr/wdata GPR write port; gpr_wen is a registered one-cycle pulse
//   wb_done             retire pulse, raised in the same cycle as the write slot
//   busy_valid, busy_rd pending destination for hazard checks (busy_rd is 0 if no write)
module ysyx_24100006_wbu #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_reg_wen,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [1:0]            in_addr_lo,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  gpr_wen,
    output logic [ADDR_WIDTH-1:0] gpr_waddr,
    output logic [DATA_WIDTH-1:0] gpr_wdata,
    output logic                  wb_done,
    output logic                  busy_valid,
    output logic [ADDR_WIDTH-1:0] busy_rd
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_WRITE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  reg_wen_q;
    logic [2:0]            funct3_q;
    logic [1:0]            addr_lo_q;
    logic                  accept;
    logic                  mem_fire;

    // Select the addressed lane and extend it. addr_lo[0] is ignored for
    // halfwords, so a misaligned halfword reads the aligned lane.
    function automatic logic [DATA_WIDTH-1:0] load_ext(
        input logic [DATA_WIDTH-1:0] word,
        input logic [2:0]            f3,
        input logic [1:0]            lo
    );
        logic signed [7:0]     b;
        logic signed [15:0]    h;
        logic [DATA_WIDTH-1:0] r;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    r = {{(DATA_WIDTH-8){b[7]}}, b};
            3'd1:    r = {{(DATA_WIDTH-16){h[15]}}, h};
            3'd4:    r = {{(DATA_WIDTH-8){1'b0}}, b};
            3'd5:    r = {{(DATA_WIDTH-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshakes are suppressed while reset is high. This drops a load
    // response that arrives in the same cycle as reset.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        mem_rready = 1'b0;
        accept     = 1'b0;
        mem_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = !reset;
                accept   = in_valid && !reset;
                if (accept) begin
                    state_nxt = in_is_load ? S_WAIT_MEM : S_WRITE;
                end
            end
            S_WAIT_MEM: begin
                mem_rready = !reset;
                mem_fire   = mem_rvalid && !reset;
                if (mem_fire) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_valid = (state != S_IDLE);
        busy_rd    = (busy_valid && reg_wen_q) ? rd_q : '0;
    end

    // Write slot registers: they are loaded on the edge that enters WRITE, so
    // the write and the retire pulse are visible for exactly the WRITE cycle.
    // waddr/wdata keep their value between slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q      <= '0;
            reg_wen_q <= 1'b0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            gpr_wen   <= 1'b0;
            wb_done   <= 1'b0;
            gpr_waddr <= '0;
            gpr_wdata <= '0;
        end else begin
            gpr_wen <= 1'b0;
            wb_done <= 1'b0;
            if (accept) begin
                rd_q      <= in_rd;
                reg_wen_q <= in_reg_wen;
                funct3_q  <= in_funct3;
                addr_lo_q <= in_addr_lo;
                if (!in_is_load) begin
                    gpr_wen   <= in_reg_wen && (in_rd != '0);
                    wb_done   <= 1'b1;
                    gpr_waddr <= in_rd;
                    gpr_wdata <= in_result;
                end
            end
            if (mem_fire) begin
                gpr_wen   <= reg_wen_q && (rd_q != '0);
                wb_done   <= 1'b1;
                gpr_waddr <= rd_q;
                gpr_wdata <= load_ext(mem_rdata, funct3_q, addr_lo_q);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24100006_wbu.sv
// Bench for ysyx_24100006_wbu. The driver schedules every transaction on a
// cycle timeline. For each cycle it records what the outputs must be: write
// slot contents, ready signals and busy information. One compare process
// checks the DUT against that timeline on every falling edge.
module tb_ysyx_24100006_wbu;
    localparam int N = 8192;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_rd = '0;
    logic        in_reg_wen = 1'b0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [1:0]  in_addr_lo = '0;
    logic [31:0] in_result = '0;
    logic        mem_rvalid = 1'b0;
    logic        mem_rready;
    logic [31:0] mem_rdata = '0;
    logic        gpr_wen;
    logic [3:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        wb_done;
    logic        busy_valid;
    logic [3:0]  busy_rd;

    ysyx_24100006_wbu #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_reg_wen(in_reg_wen), .in_is_load(in_is_load), .in_funct3(in_funct3),
        .in_addr_lo(in_addr_lo), .in_result(in_result),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .wb_done(wb_done), .busy_valid(busy_valid), .busy_rd(busy_rd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected timeline, indexed by cycle number.
    bit          e_ready [N];
    bit          e_mrr   [N];
    bit          e_wen   [N];
    bit          e_done  [N];
    bit          e_busy  [N];
    bit          e_clr   [N];
    logic [3:0]  e_brd   [N];
    logic [3:0]  e_addr  [N];
    logic [31:0] e_data  [N];

    int  checks = 0;
    int  fails = 0;
    bit  fin = 1'b0;
    logic [3:0]  last_a = '0;
    logic [31:0] last_d = '0;

    // Reference load result: shift the word down to the addressed lane, mask
    // it, then extend it by arithmetic.
    function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] lo);
        int unsigned b;
        int unsigned h;
        int          s;
        b = (w >> (8 * int'(lo))) & 32'hFF;
        h = (w >> (16 * int'(lo[1]))) & 32'hFFFF;
        case (f3)
            3'd0: begin s = int'(b); if (s >= 128) s = s - 256; return 32'(s); end
            3'd1: begin s = int'(h); if (s >= 32768) s = s - 65536; return 32'(s); end
            3'd4: return 32'(b);
            3'd5: return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < N && !fin) begin
            if (cyc == 1) begin
                chk("model_lb",  m_ext(32'h8070F0A5, 3'd0, 2'd0), 32'hFFFFFFA5);
                chk("model_lbu", m_ext(32'h8070F0A5, 3'd4, 2'd1), 32'h000000F0);
                chk("model_lh",  m_ext(32'h8070F0A5, 3'd1, 2'd2), 32'hFFFF8070);
                chk("model_lhu", m_ext(32'h8070F0A5, 3'd5, 2'd2), 32'h00008070);
                chk("model_lw",  m_ext(32'h8070F0A5, 3'd2, 2'd0), 32'h8070F0A5);
                chk("model_f3_7", m_ext(32'h8070F0A5, 3'd7, 2'd3), 32'h8070F0A5);
            end
            if (e_clr[cyc]) begin
                last_a = '0;
                last_d = '0;
            end
            if (e_done[cyc]) begin
                last_a = e_addr[cyc];
                last_d = e_data[cyc];
            end
            chk("gpr_wen",    32'(gpr_wen),    32'(e_wen[cyc]));
            chk("wb_done",    32'(wb_done),    32'(e_done[cyc]));
            chk("gpr_waddr",  32'(gpr_waddr),  32'(last_a));
            chk("gpr_wdata",  gpr_wdata,       last_d);
            chk("busy_valid", 32'(busy_valid), 32'(e_busy[cyc]));
            chk("busy_rd",    32'(busy_rd),    32'(e_brd[cyc]));
            if (!reset) begin
                chk("in_ready",   32'(in_ready),   32'(e_ready[cyc]));
                chk("mem_rready", 32'(mem_rready), 32'(e_mrr[cyc]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_busy(input int c, input logic [3:0] rd, input bit wen, input bit mrr);
        e_ready[c] = 1'b0;
        e_mrr[c]   = mrr;
        e_busy[c]  = 1'b1;
        e_brd[c]   = wen ? rd : 4'd0;
    endtask

    task automatic exp_write(input int c, input logic [3:0] rd, input bit wen, input logic [31:0] d);
        exp_busy(c, rd, wen, 1'b0);
        e_wen[c]  = wen && (rd != 4'd0);
        e_done[c] = 1'b1;
        e_addr[c] = rd;
        e_data[c] = d;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid   = 1'b0;
            mem_rvalid = 1'($urandom);
            mem_rdata  = $urandom;
            tick();
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic do_alu(input logic [3:0] rd, input bit wen, input logic [31:0] res, input bit hold);
        int a;
        a = cyc;
        in_valid   = 1'b1;
        in_is_load = 1'b0;
        in_rd      = rd;
        in_reg_wen = wen;
        in_result  = res;
        in_funct3  = 3'($urandom);
        in_addr_lo = 2'($urandom);
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        exp_write(a + 1, rd, wen, res);
        tick();
        in_valid   = hold;
        mem_rvalid = 1'($urandom);
        tick();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] rd, input bit wen, input logic [2:0] f3,
                           input logic [1:0] lo, input logic [31:0] rdata, input int delay,
                           input bit rst_at_resp);
        int a;
        int m;
        a = cyc;
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_rd      = rd;
        in_reg_wen = wen;
        in_funct3  = f3;
        in_addr_lo = lo;
        in_result  = $urandom;
        mem_rvalid = 1'b0;
        tick();
        for (int k = 0; k < delay; k++) begin
            exp_busy(cyc, rd, wen, 1'b1);
            in_valid   = 1'($urandom);
            in_is_load = 1'($urandom);
            in_rd      = 4'($urandom);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            tick();
        end
        m = cyc;
        exp_busy(m, rd, wen, 1'b1);
        in_valid   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        if (rst_at_resp) begin
            reset = 1'b1;
            e_clr[m + 1] = 1'b1;
            tick();
            reset      = 1'b0;
            mem_rvalid = 1'b0;
            tick();
        end else begin
            exp_write(m + 1, rd, wen, m_ext(rdata, f3, lo));
            tick();
            in_valid   = 1'($urandom);
            mem_rvalid = 1'($urandom);
            tick();
            in_valid   = 1'b0;
            mem_rvalid = 1'b0;
        end
    endtask

    initial begin
        int op;
        for (int i = 0; i < N; i++) begin
            e_ready[i] = 1'b1;
            e_mrr[i]   = 1'b0;
            e_wen[i]   = 1'b0;
            e_done[i]  = 1'b0;
            e_busy[i]  = 1'b0;
            e_clr[i]   = 1'b0;
            e_brd[i]   = '0;
            e_addr[i]  = '0;
            e_data[i]  = '0;
        end
        e_clr[1] = 1'b1;
        e_clr[2] = 1'b1;
        e_clr[3] = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b0;
        idle_cycles(2);

        // Directed scenarios
        do_alu(4'd5, 1'b1, 32'h12345678, 1'b0);
        do_alu(4'd0, 1'b1, 32'hFFFFFFFF, 1'b0);
        do_alu(4'd3, 1'b0, 32'hCAFEF00D, 1'b0);
        do_load(4'd1, 1'b1, 3'd0, 2'd0, 32'h8070F0A5, 0, 1'b0);
        do_load(4'd2, 1'b1, 3'd4, 2'd1, 32'h8070F0A5, 0, 1'b0);
        do_load(4'd3, 1'b1, 3'd1, 2'd2, 32'h8070F0A5, 1, 1'b0);
        do_load(4'd4, 1'b1, 3'd5, 2'd2, 32'h8070F0A5, 0, 1'b0);
        do_load(4'd6, 1'b1, 3'd2, 2'd0, 32'h8070F0A5, 2, 1'b0);
        do_load(4'd7, 1'b1, 3'd2, 2'd0, 32'h0BADBEEF, 5, 1'b0);
        idle_cycles(4);
        do_alu(4'd9, 1'b1, 32'h00C0FFEE, 1'b1);
        idle_cycles(1);
        do_load(4'd8, 1'b1, 3'd0, 2'd3, 32'h11223344, 3, 1'b1);
        do_alu(4'd10, 1'b1, 32'hA5A5A5A5, 1'b0);

        // Randomized traffic
        while (cyc < N - 60) begin
            op = int'($urandom_range(0, 19));
            if (op < 9) begin
                do_alu(4'($urandom), 1'($urandom), $urandom, 1'($urandom));
            end else if (op < 17) begin
                do_load(4'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), $urandom,
                        int'($urandom_range(0, 6)), 1'b0);
            end else if (op < 18) begin
                do_load(4'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), $urandom,
                        int'($urandom_range(0, 4)), 1'b1);
            end else begin
                idle_cycles(int'($urandom_range(1, 3)));
            end
            if (cyc > 3000) break;
        end
        idle_cycles(3);
        fin = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
